// File: rtl/irq_controller_if.sv
// Peripheral/core/config-bus bundle for irq_controller.
// master = core + peripherals + config host; slave = the controller.
interface irq_controller_if #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 4
);
  logic [NUM_SRC-1:0] irq_src;
  logic               reg_wr;
  logic [1:0]         reg_addr;
  logic [31:0]        reg_wdata;
  logic [31:0]        reg_rdata;
  logic               interrput;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               irq_eoi;

  modport master (
    output irq_src, reg_wr, reg_addr, reg_wdata, irq_ack, irq_eoi,
    input  reg_rdata, interrput, irq_id
  );

  modport slave (
    input  irq_src, reg_wr, reg_addr, reg_wdata, irq_ack, irq_eoi,
    output reg_rdata, interrput, irq_id
  );
endinterface

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: pending/mask registers, lowest-index priority, ack/eoi handshake.
// Define IRQ_SYNC_EN to insert a 2-flop synchronizer on irq_src (edge-to-request latency 4 instead of 2).
module irq_controller #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  irq_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_irq;
  logic               w_irq_nxt;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    w_id_nxt;
  logic [ID_W-1:0]    w_lowest;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] w_src;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_sel;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [NUM_SRC-1:0] w_w1c;
  logic               w_mask_wr;
  logic               w_unused_wdata;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = bus.irq_src;
`endif

  assign w_edge         = w_src & ~r_prev;
  assign w_active       = r_pending & r_mask;
  assign w_sel          = NUM_SRC'(1) << r_id;
  assign w_mask_wr      = bus.reg_wr && (bus.reg_addr == 2'd0);
  assign w_w1c          = (bus.reg_wr && (bus.reg_addr == 2'd1)) ? bus.reg_wdata[NUM_SRC-1:0] : '0;
  assign w_unused_wdata = ^bus.reg_wdata[31:NUM_SRC];

  // Descending scan so the lowest active index is the final assignment.
  always_comb begin
    w_lowest = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (w_active[i-1]) w_lowest = ID_W'(i - 1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_id_nxt    = r_id;
    w_ack_clr   = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_active) begin
          w_state_nxt = S_REQ;
          w_irq_nxt   = 1'b1;
          w_id_nxt    = w_lowest;
        end
      end
      S_REQ: begin
        if (bus.irq_ack) begin
          w_state_nxt = S_SERVICE;
          w_irq_nxt   = 1'b0;
          w_ack_clr   = w_sel;
        end else if (!(|(w_sel & r_mask & r_pending))) begin
          w_state_nxt = S_IDLE;
          w_irq_nxt   = 1'b0;
        end
      end
      S_SERVICE: begin
        w_irq_nxt = 1'b0;
        if (bus.irq_eoi) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_irq_nxt   = 1'b0;
      end
    endcase
  end

  // A fresh edge wins over both the ack clear and a W1C of the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_irq     <= 1'b0;
      r_id      <= '0;
      r_mask    <= '0;
      r_pending <= '0;
      r_prev    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq     <= w_irq_nxt;
      r_id      <= w_id_nxt;
      r_prev    <= w_src;
      r_pending <= (r_pending & ~w_ack_clr & ~w_w1c) | w_edge;
      if (w_mask_wr) r_mask <= bus.reg_wdata[NUM_SRC-1:0];
    end
  end

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      2'd0: bus.reg_rdata[NUM_SRC-1:0] = r_mask;
      2'd1: bus.reg_rdata[NUM_SRC-1:0] = r_pending;
      2'd2: begin
        bus.reg_rdata[1:0]      = r_state;
        bus.reg_rdata[8 +: ID_W] = r_id;
      end
      default: bus.reg_rdata = '0;
    endcase
  end

  assign bus.interrput = r_irq;
  assign bus.irq_id    = r_id;

endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios plus randomized traffic for irq_controller against a cycle-level reference model.
module tb_irq_controller;
  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned ID_W    = 4;
  localparam logic [31:0] ALL     = 32'h0000_00FF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_controller_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

  irq_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference state: 0 idle, 1 requesting, 2 in service.
  logic [31:0] m_mask = '0, m_pend = '0, m_prev = '0, m_s1 = '0, m_s2 = '0;
  int          m_state = 0;
  logic [31:0] m_irq = '0;
  logic [31:0] m_id  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] lowest(input logic [31:0] v);
    for (int i = 0; i < int'(NUM_SRC); i++) if (v[i]) return 32'(i);
    return '0;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_pend;
      2'd2:    return 32'(m_state) | (m_id << 8);
      default: return '0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs held during the cycle that just ended.
  task automatic model_step();
    logic [31:0] smp, edges, clr, sel;
    if (rst) begin
      m_mask = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_state = 0; m_irq = '0; m_id = '0;
      return;
    end
`ifdef IRQ_SYNC_EN
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = 32'(bus.irq_src);
`else
    smp  = 32'(bus.irq_src);
`endif
    edges  = smp & ~m_prev;
    m_prev = smp;
    clr    = (bus.reg_wr && bus.reg_addr == 2'd1) ? (bus.reg_wdata & ALL) : '0;
    sel    = 32'd1 << m_id;
    if (m_state == 0) begin
      if ((m_pend & m_mask) != 0) begin
        m_id = lowest(m_pend & m_mask); m_state = 1; m_irq = 32'd1;
      end
    end else if (m_state == 1) begin
      if (bus.irq_ack) begin
        clr = clr | sel; m_state = 2; m_irq = '0;
      end else if ((m_mask & m_pend & sel) == 0) begin
        m_state = 0; m_irq = '0;
      end
    end else if (bus.irq_eoi) begin
      m_state = 0;
    end
    m_pend = (m_pend & ~clr) | edges;
    if (bus.reg_wr && bus.reg_addr == 2'd0) m_mask = bus.reg_wdata & ALL;
  endtask

  task automatic cyc(input logic r, input logic [7:0] src, input logic wr, input logic [1:0] addr,
                     input logic [31:0] wd, input logic ack, input logic eoi);
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = r; bus.irq_src = src; bus.reg_wr = wr; bus.reg_addr = addr;
    bus.reg_wdata = wd; bus.irq_ack = ack; bus.irq_eoi = eoi;
    #1;
    check("interrput", 32'(bus.interrput), m_irq);
    check("irq_id", 32'(bus.irq_id), m_id);
    check("reg_rdata", bus.reg_rdata, exp_rdata(addr));
  endtask

  initial begin
    logic [7:0]  src;
    logic        r, wr, ack, eoi;
    logic [1:0]  addr;
    logic [31:0] wd;

    rst = 1'b1; bus.irq_src = '0; bus.reg_wr = 1'b0; bus.reg_addr = '0;
    bus.reg_wdata = '0; bus.irq_ack = 1'b0; bus.irq_eoi = 1'b0;

    // Reset state
    cyc(1, 8'h00, 0, 2'd0, 0, 0, 0);
    for (int a = 0; a < 4; a++) begin
      cyc(1, 8'h00, 0, 2'(a), 0, 0, 0);
      check("t1_rdata", bus.reg_rdata, 32'd0);
    end
    check("t1_irq", 32'(bus.interrput), 32'd0);
    check("t1_id", 32'(bus.irq_id), 32'd0);

    // Single source, full ack/eoi handshake
    cyc(0, 8'h00, 1, 2'd0, 32'hFF, 0, 0);
    cyc(0, 8'h08, 0, 2'd1, 0, 0, 0);
    check("t2_pend_n", bus.reg_rdata, 32'h00);
    cyc(0, 8'h08, 0, 2'd1, 0, 0, 0);
    check("t2_pend_n1", bus.reg_rdata, 32'h08);
    check("t2_irq_n1", 32'(bus.interrput), 32'd0);
    cyc(0, 8'h08, 0, 2'd2, 0, 1, 0);
    check("t2_irq_n2", 32'(bus.interrput), 32'd1);
    check("t2_id_n2", 32'(bus.irq_id), 32'd3);
    check("t2_status_req", bus.reg_rdata, 32'h301);
    cyc(0, 8'h08, 0, 2'd1, 0, 0, 0);
    check("t2_pend_ack", bus.reg_rdata, 32'h00);
    cyc(0, 8'h08, 0, 2'd2, 0, 0, 1);
    check("t2_status_svc", bus.reg_rdata, 32'h302);
    cyc(0, 8'h08, 0, 2'd2, 0, 0, 0);
    check("t2_status_eoi", bus.reg_rdata, 32'h300);

    // Priority among simultaneous edges, masked source never served
    cyc(0, 8'h00, 1, 2'd0, 32'h30, 0, 0);
    cyc(0, 8'h34, 0, 2'd1, 0, 0, 0);
    cyc(0, 8'h34, 0, 2'd1, 0, 0, 0);
    check("t3_pend", bus.reg_rdata, 32'h34);
    cyc(0, 8'h34, 0, 2'd2, 0, 1, 0);
    check("t3_id4", 32'(bus.irq_id), 32'd4);
    cyc(0, 8'h34, 0, 2'd1, 0, 0, 1);
    check("t3_pend_after4", bus.reg_rdata, 32'h24);
    cyc(0, 8'h34, 0, 2'd2, 0, 0, 0);
    check("t3_status_idle", bus.reg_rdata, 32'h400);
    // Withdraw by masking while requesting id 5
    cyc(0, 8'h34, 1, 2'd0, 32'h00, 0, 0);
    check("t3_irq_id5", 32'(bus.interrput), 32'd1);
    check("t3_id5", 32'(bus.irq_id), 32'd5);
    cyc(0, 8'h34, 0, 2'd2, 0, 0, 0);
    cyc(0, 8'h34, 0, 2'd1, 0, 0, 0);
    check("t4_irq_withdrawn", 32'(bus.interrput), 32'd0);
    check("t4_pend_kept", bus.reg_rdata, 32'h24);
    cyc(0, 8'h34, 0, 2'd2, 0, 0, 0);
    check("t4_status_idle", bus.reg_rdata, 32'h500);

    // New edge on the acked bit in the ack cycle keeps it pending
    cyc(0, 8'h00, 1, 2'd1, 32'hFF, 0, 0);
    cyc(0, 8'h00, 1, 2'd0, 32'h02, 0, 0);
    cyc(0, 8'h02, 0, 2'd1, 0, 0, 0);
    cyc(0, 8'h00, 0, 2'd1, 0, 0, 0);
    cyc(0, 8'h02, 0, 2'd1, 0, 1, 0);
    check("t5_id1", 32'(bus.irq_id), 32'd1);
    cyc(0, 8'h02, 0, 2'd1, 0, 0, 1);
    check("t5_pend_set_wins", bus.reg_rdata, 32'h02);
    cyc(0, 8'h02, 0, 2'd2, 0, 0, 0);
    check("t5_status_idle", bus.reg_rdata, 32'h100);
    cyc(0, 8'h02, 0, 2'd2, 0, 1, 0);
    check("t5_rereq", bus.reg_rdata, 32'h101);

    // Reset while in service
    cyc(1, 8'h02, 0, 2'd2, 0, 0, 0);
    check("t6_status_pre", bus.reg_rdata, 32'h102);
    cyc(0, 8'h02, 0, 2'd1, 0, 0, 0);
    check("t6_pend", bus.reg_rdata, 32'h00);
    check("t6_irq", 32'(bus.interrput), 32'd0);
    check("t6_id", 32'(bus.irq_id), 32'd0);
    cyc(0, 8'h02, 0, 2'd0, 0, 0, 0);
    check("t6_mask", bus.reg_rdata, 32'h00);

    // Randomized traffic
    src = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      src  = src ^ 8'($urandom & $urandom & $urandom);
      r    = ($urandom_range(0, 199) == 0);
      wr   = ($urandom_range(0, 5) == 0);
      addr = 2'($urandom_range(0, 3));
      wd   = $urandom;
      ack  = (m_state == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      eoi  = (m_state == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cyc(r, src, wr, addr, wd, ack, eoi);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
